x86_insn_byte_parser: RTL and testbench
=======================================

Name: x86_insn_byte_parser

Overview:
- Consumes the fetched x86-64 instruction byte stream one byte per cycle and splits it into instruction boundaries and fields: legacy prefixes, REX, opcode (one-byte or 0F-escaped), ModRM, SIB, displacement and immediate.
- Applies the opcode-table rules (mnemonic class, ModRM presence, immediate size) in hardware.
- Sits between the fetch byte queue and the decode/mnemonic lookup stage, and emits one parsed instruction per output handshake.

Parameters:
MAX_LEN, 15, architectural instruction length limit in bytes.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_byte is valid
in_byte  input  8  next instruction-stream byte
in_ready  output  1  parser accepts in_byte this cycle
out_valid  output  1  parsed instruction available
out_ready  input  1  downstream accepts instruction
out_pfx  output  6  [0]=66 [1]=67 [2]=F0 [3]=F2 [4]=F3 [5]=segment prefix seen
out_seg  output  3  last segment prefix: ES0 CS1 SS2 DS3 FS4 GS5
out_rex  output  4  REX.WRXB (0 if no REX)
out_escape  output  1  opcode was 0F-escaped
out_opcode  output  8  opcode byte
out_has_modrm, out_has_sib  output  1 each  field present
out_modrm, out_sib  output  8 each  field values (0 if absent)
out_disp  output  32  displacement, sign-extended from disp8
out_imm  output  64  immediate, little-endian assembled, zero-filled above imm_bytes
out_imm_bytes  output  4  immediate byte count, 0/1/2/3/4/8
out_length  output  4  total bytes, 1..15
out_error  output  1  invalid opcode or length overflow

Behaviour:
- Reset: all outputs 0, except in_ready=1. Reset drops any partial instruction, and the next accepted byte starts a new instruction.
- States:
  - PFX: PFX→PFX on a legacy prefix (26,2E,36,3E,64,65,66,67,F0,F2,F3) or REX (40-4F). PFX→OP2 on 0F. PFX→MODRM, IMM or DONE on any other byte, which is the opcode.
  - OP2: →MODRM, IMM or DONE.
  - MODRM: →SIB, DISP, IMM or DONE.
  - SIB: →DISP, IMM or DONE.
  - DISP: →IMM or DONE.
  - IMM: →DONE.
- REX counts only if it is immediately before the opcode. A legacy prefix following REX clears the latched REX.
- One-byte opcodes with ModRM: rows 0x00-0x3F with low nibble 0-3 or 8-B, plus 63, 69, 6B, 80-8F, C0, C1, C6, C7, D0-D3, D8-DF, F6, F7, FE, FF.
- Two-byte opcodes have ModRM except 0F 05, 0B, 31, A2, 80-8F, C8-CF.
- Addressing (ModRM present):
  - SIB present when mod≠11 and rm=100.
  - disp32 when mod=10, or mod=00 with rm=101, or mod=00 with SIB.base=101.
  - disp8 when mod=01.
- Immediate sizes, where Z = 2 if 66 seen else 4:
  - imm8: 04,0C,14,1C,24,2C,34,3C, 6A, 6B, 70-7F, 80, 83, A8, B0-B7, C0, C1, C6, CD, E0-E7, EB, F6 with reg=0/1, 0F BA/A4/AC/70-73.
  - imm16: C2, CA.
  - 3 bytes: C8.
  - Z: 05,0D,15,1D,25,2D,35,3D, 68, 69, 81, A9, C7, E8, E9, F7 with reg=0/1, 0F 80-8F.
  - B8-BF: 8 if REX.W, else Z.
  - A0-A3: 8, or 4 if 67 seen.
- Invalid in 64-bit mode: 06,07,0E,16,17,1E,1F,27,2F,37,3F,60,61,62,82,9A,C4,C5,D4,D5,D6,EA. These emit immediately after the opcode byte with out_error=1.
- Length overflow: if the 15th byte is accepted and the instruction is incomplete, emit with out_error=1 and out_length=15. The next byte starts a new instruction.
- Handshake and latency:
  - in_ready=1 in every state except DONE.
  - out_valid rises the cycle after the final byte is accepted, and all out_* hold stable until out_valid && out_ready.
  - in_ready returns the cycle after that handshake.
  - Bytes with in_valid=0 are ignored without state change.

Test Plan:
- 48 89 E5 → rex=8, opcode=89, modrm=E5, has_sib=0, imm_bytes=0, length=3, error=0.
- 66 81 C1 34 12 → pfx[0]=1, modrm=C1, imm=0x1234, imm_bytes=2, length=5.
- 48 B8 88 77 66 55 44 33 22 11 → imm=0x1122334455667788, imm_bytes=8, length=10.
- 8B 44 24 F8 then 0F 84 10 00 00 00:
  - First instruction: sib=24, disp=0xFFFFFFF8, length=4.
  - Second instruction: escape=1, opcode=84, imm=0x10, imm_bytes=4, length=6.
  - Hold out_ready=0 for 3 cycles between the two: outputs stable, in_ready=0.
- 15×66 then 90 → first out: error=1, length=15. Second out: opcode=90, length=1, pfx=0.
- 48 66 90 → rex=0, pfx[0]=1. Then 8B 44 with reset asserted → no output. Then 90 → opcode=90, length=1. Then 06 → error=1, length=1.

Source files
------------

// File: rtl/x86_insn_byte_parser.sv
// x86-64 instruction byte parser: consumes one instruction-stream byte per
// cycle and splits it into prefixes, REX, opcode, ModRM, SIB, displacement
// and immediate, presenting one parsed instruction per output handshake.
module x86_insn_byte_parser #(
  parameter int MAX_LEN = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_pfx,
  output logic [2:0]  out_seg,
  output logic [3:0]  out_rex,
  output logic        out_escape,
  output logic [7:0]  out_opcode,
  output logic        out_has_modrm,
  output logic        out_has_sib,
  output logic [7:0]  out_modrm,
  output logic [7:0]  out_sib,
  output logic [31:0] out_disp,
  output logic [63:0] out_imm,
  output logic [3:0]  out_imm_bytes,
  output logic [3:0]  out_length,
  output logic        out_error
);

  typedef enum logic [2:0] {
    S_PFX, S_OP2, S_MODRM, S_SIB, S_DISP, S_IMM, S_DONE
  } state_t;

  state_t       state_q, state_d;
  logic [5:0]   pfx_q, pfx_d;
  logic [2:0]   seg_q, seg_d;
  logic [3:0]   rex_q, rex_d;
  logic         esc_q, esc_d;
  logic [7:0]   opcode_q, opcode_d;
  logic         has_modrm_q, has_modrm_d;
  logic         has_sib_q, has_sib_d;
  logic [7:0]   modrm_q, modrm_d;
  logic [7:0]   sib_q, sib_d;
  logic [31:0]  disp_q, disp_d;
  logic [63:0]  imm_q, imm_d;
  logic [3:0]   imm_bytes_q, imm_bytes_d;
  logic [2:0]   dsz_q, dsz_d;
  logic [2:0]   idx_q, idx_d;
  logic [3:0]   len_q, len_d;
  logic         err_q, err_d;

  logic         op_take, op_esc;
  logic [3:0]   isz;
  logic [2:0]   dsz;
  logic [3:0]   len_inc;

  function automatic logic is_legacy(input logic [7:0] b);
    case (b)
      8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
      8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: is_legacy = 1'b1;
      default:                           is_legacy = 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] seg_code(input logic [7:0] b);
    case (b)
      8'h26:   seg_code = 3'd0;
      8'h2E:   seg_code = 3'd1;
      8'h36:   seg_code = 3'd2;
      8'h3E:   seg_code = 3'd3;
      8'h64:   seg_code = 3'd4;
      8'h65:   seg_code = 3'd5;
      default: seg_code = 3'd0;
    endcase
  endfunction

  function automatic logic invalid1(input logic [7:0] op);
    case (op)
      8'h06, 8'h07, 8'h0E, 8'h16, 8'h17, 8'h1E, 8'h1F, 8'h27, 8'h2F,
      8'h37, 8'h3F, 8'h60, 8'h61, 8'h62, 8'h82, 8'h9A, 8'hC4, 8'hC5,
      8'hD4, 8'hD5, 8'hD6, 8'hEA: invalid1 = 1'b1;
      default:                    invalid1 = 1'b0;
    endcase
  endfunction

  // ALU rows 00-3F carry ModRM in the forms whose low nibble is 0-3 or 8-B
  function automatic logic modrm1(input logic [7:0] op);
    if (op[7:6] == 2'b00 && !op[2]) begin
      modrm1 = 1'b1;
    end else begin
      casez (op)
        8'h63, 8'h69, 8'h6B, 8'b1000_????, 8'hC0, 8'hC1, 8'hC6, 8'hC7,
        8'b1101_00??, 8'b1101_1???, 8'hF6, 8'hF7, 8'hFE, 8'hFF:
                 modrm1 = 1'b1;
        default: modrm1 = 1'b0;
      endcase
    end
  endfunction

  function automatic logic modrm2(input logic [7:0] op);
    casez (op)
      8'h05, 8'h0B, 8'h31, 8'hA2, 8'b1000_????, 8'b1100_1???:
               modrm2 = 1'b0;
      default: modrm2 = 1'b1;
    endcase
  endfunction

  // Immediate byte count; reg is the ModRM reg field (only F6/F7 use it)
  function automatic logic [3:0] imm_size(input logic esc, input logic [7:0] op,
                                          input logic [2:0] rg, input logic p66,
                                          input logic p67, input logic w);
    logic [3:0] z;
    z = p66 ? 4'd2 : 4'd4;
    imm_size = 4'd0;
    if (esc) begin
      casez (op)
        8'hBA, 8'hA4, 8'hAC, 8'b0111_00??: imm_size = 4'd1;
        8'b1000_????:                      imm_size = z;
        default:                           imm_size = 4'd0;
      endcase
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b100) begin
      imm_size = 4'd1;
    end else if (op[7:6] == 2'b00 && op[2:0] == 3'b101) begin
      imm_size = z;
    end else begin
      casez (op)
        8'h6A, 8'h6B, 8'b0111_????, 8'h80, 8'h83, 8'hA8, 8'b1011_0???,
        8'hC0, 8'hC1, 8'hC6, 8'hCD, 8'b1110_0???, 8'hEB:
                      imm_size = 4'd1;
        8'hC2, 8'hCA: imm_size = 4'd2;
        8'hC8:        imm_size = 4'd3;
        8'h68, 8'h69, 8'h81, 8'hA9, 8'hC7, 8'hE8, 8'hE9:
                      imm_size = z;
        8'b1011_1???: imm_size = w ? 4'd8 : z;
        8'b1010_00??: imm_size = p67 ? 4'd4 : 4'd8;
        8'hF6:        imm_size = (rg[2:1] == 2'b00) ? 4'd1 : 4'd0;
        8'hF7:        imm_size = (rg[2:1] == 2'b00) ? z : 4'd0;
        default:      imm_size = 4'd0;
      endcase
    end
  endfunction

  function automatic state_t after_addr(input logic [2:0] d, input logic [3:0] i);
    if (d != 3'd0)      after_addr = S_DISP;
    else if (i != 4'd0) after_addr = S_IMM;
    else                after_addr = S_DONE;
  endfunction

  assign in_ready      = (state_q != S_DONE);
  assign out_valid     = (state_q == S_DONE);
  assign out_pfx       = pfx_q;
  assign out_seg       = seg_q;
  assign out_rex       = rex_q;
  assign out_escape    = esc_q;
  assign out_opcode    = opcode_q;
  assign out_has_modrm = has_modrm_q;
  assign out_has_sib   = has_sib_q;
  assign out_modrm     = modrm_q;
  assign out_sib       = sib_q;
  assign out_disp      = disp_q;
  assign out_imm       = imm_q;
  assign out_imm_bytes = imm_bytes_q;
  assign out_length    = len_q;
  assign out_error     = err_q;

  // Next-state and field capture for each accepted byte or output handshake
  always_comb begin
    state_d     = state_q;
    pfx_d       = pfx_q;
    seg_d       = seg_q;
    rex_d       = rex_q;
    esc_d       = esc_q;
    opcode_d    = opcode_q;
    has_modrm_d = has_modrm_q;
    has_sib_d   = has_sib_q;
    modrm_d     = modrm_q;
    sib_d       = sib_q;
    disp_d      = disp_q;
    imm_d       = imm_q;
    imm_bytes_d = imm_bytes_q;
    dsz_d       = dsz_q;
    idx_d       = idx_q;
    len_d       = len_q;
    err_d       = err_q;
    op_take     = 1'b0;
    op_esc      = 1'b0;
    isz         = 4'd0;
    dsz         = 3'd0;
    len_inc     = len_q + 4'd1;

    if (state_q == S_DONE) begin
      // Clearing on handshake makes absent fields read as zero next time
      if (out_ready) begin
        state_d     = S_PFX;
        pfx_d       = '0;
        seg_d       = '0;
        rex_d       = '0;
        esc_d       = 1'b0;
        opcode_d    = '0;
        has_modrm_d = 1'b0;
        has_sib_d   = 1'b0;
        modrm_d     = '0;
        sib_d       = '0;
        disp_d      = '0;
        imm_d       = '0;
        imm_bytes_d = '0;
        dsz_d       = '0;
        idx_d       = '0;
        len_d       = '0;
        err_d       = 1'b0;
      end
    end else if (in_valid) begin
      len_d = len_inc;
      case (state_q)
        S_PFX: begin
          if (is_legacy(in_byte)) begin
            // A REX is only meaningful directly before the opcode
            rex_d = 4'd0;
            case (in_byte)
              8'h66:   pfx_d[0] = 1'b1;
              8'h67:   pfx_d[1] = 1'b1;
              8'hF0:   pfx_d[2] = 1'b1;
              8'hF2:   pfx_d[3] = 1'b1;
              8'hF3:   pfx_d[4] = 1'b1;
              default: begin
                pfx_d[5] = 1'b1;
                seg_d    = seg_code(in_byte);
              end
            endcase
          end else if (in_byte[7:4] == 4'h4) begin
            rex_d = in_byte[3:0];
          end else if (in_byte == 8'h0F) begin
            esc_d   = 1'b1;
            state_d = S_OP2;
          end else begin
            op_take = 1'b1;
          end
        end
        S_OP2: begin
          op_take = 1'b1;
          op_esc  = 1'b1;
        end
        S_MODRM: begin
          modrm_d     = in_byte;
          isz         = imm_size(esc_q, opcode_q, in_byte[5:3], pfx_q[0], pfx_q[1], rex_q[3]);
          imm_bytes_d = isz;
          if (in_byte[7:6] != 2'b11 && in_byte[2:0] == 3'b100) begin
            has_sib_d = 1'b1;
            state_d   = S_SIB;
          end else begin
            if (in_byte[7:6] == 2'b01)
              dsz = 3'd1;
            else if (in_byte[7:6] == 2'b10 || (in_byte[7:6] == 2'b00 && in_byte[2:0] == 3'b101))
              dsz = 3'd4;
            dsz_d   = dsz;
            state_d = after_addr(dsz, isz);
          end
        end
        S_SIB: begin
          sib_d = in_byte;
          if (modrm_q[7:6] == 2'b01)
            dsz = 3'd1;
          else if (modrm_q[7:6] == 2'b10 || (modrm_q[7:6] == 2'b00 && in_byte[2:0] == 3'b101))
            dsz = 3'd4;
          dsz_d   = dsz;
          state_d = after_addr(dsz, imm_bytes_q);
        end
        S_DISP: begin
          if (dsz_q == 3'd1)
            disp_d = {{24{in_byte[7]}}, in_byte};
          else
            disp_d[{idx_q[1:0], 3'b000} +: 8] = in_byte;
          if (idx_q + 3'd1 == dsz_q) begin
            idx_d   = 3'd0;
            state_d = (imm_bytes_q != 4'd0) ? S_IMM : S_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        S_IMM: begin
          imm_d[{idx_q, 3'b000} +: 8] = in_byte;
          if ({1'b0, idx_q} + 4'd1 == imm_bytes_q) begin
            idx_d   = 3'd0;
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
        default: ;
      endcase

      // Opcode byte handling shared by one-byte and 0F-escaped maps
      if (op_take) begin
        opcode_d = in_byte;
        if (!op_esc && invalid1(in_byte)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (op_esc ? modrm2(in_byte) : modrm1(in_byte)) begin
          has_modrm_d = 1'b1;
          state_d     = S_MODRM;
        end else begin
          isz         = imm_size(op_esc, in_byte, 3'd0, pfx_q[0], pfx_q[1], rex_q[3]);
          imm_bytes_d = isz;
          state_d     = (isz != 4'd0) ? S_IMM : S_DONE;
        end
      end

      // Architectural length limit reached with bytes still expected
      if (state_d != S_DONE && len_inc == 4'(MAX_LEN)) begin
        err_d   = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  // State and field registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_PFX;
      pfx_q       <= '0;
      seg_q       <= '0;
      rex_q       <= '0;
      esc_q       <= 1'b0;
      opcode_q    <= '0;
      has_modrm_q <= 1'b0;
      has_sib_q   <= 1'b0;
      modrm_q     <= '0;
      sib_q       <= '0;
      disp_q      <= '0;
      imm_q       <= '0;
      imm_bytes_q <= '0;
      dsz_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pfx_q       <= pfx_d;
      seg_q       <= seg_d;
      rex_q       <= rex_d;
      esc_q       <= esc_d;
      opcode_q    <= opcode_d;
      has_modrm_q <= has_modrm_d;
      has_sib_q   <= has_sib_d;
      modrm_q     <= modrm_d;
      sib_q       <= sib_d;
      disp_q      <= disp_d;
      imm_q       <= imm_d;
      imm_bytes_q <= imm_bytes_d;
      dsz_q       <= dsz_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_x86_insn_byte_parser.sv
// Directed bench for x86_insn_byte_parser with hand-computed expectations.
module tb_x86_insn_byte_parser;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_pfx;
  logic [2:0]  out_seg;
  logic [3:0]  out_rex;
  logic        out_escape;
  logic [7:0]  out_opcode;
  logic        out_has_modrm;
  logic        out_has_sib;
  logic [7:0]  out_modrm;
  logic [7:0]  out_sib;
  logic [31:0] out_disp;
  logic [63:0] out_imm;
  logic [3:0]  out_imm_bytes;
  logic [3:0]  out_length;
  logic        out_error;

  int total = 0;
  int bad   = 0;

  x86_insn_byte_parser #(.MAX_LEN(15)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_pfx(out_pfx), .out_seg(out_seg), .out_rex(out_rex),
    .out_escape(out_escape), .out_opcode(out_opcode),
    .out_has_modrm(out_has_modrm), .out_has_sib(out_has_sib),
    .out_modrm(out_modrm), .out_sib(out_sib), .out_disp(out_disp),
    .out_imm(out_imm), .out_imm_bytes(out_imm_bytes),
    .out_length(out_length), .out_error(out_error)
  );

  always #5 clk = ~clk;

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic expire(input string tag);
    total++;
    bad++;
    $error("FAIL %s timeout got=0 exp=1", tag);
  endtask

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) expire("send_in_ready");
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) expire({tag, ".out_valid"});
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic expect_insn(input string tag, input logic [5:0] pfx, input logic [2:0] seg,
                             input logic [3:0] rex, input logic esc, input logic [7:0] op,
                             input logic hm, input logic [7:0] modrm, input logic hs,
                             input logic [7:0] sib, input logic [31:0] disp,
                             input logic [63:0] imm, input logic [3:0] ib,
                             input logic [3:0] len, input logic err);
    chk({tag, ".pfx"},       64'(out_pfx),       64'(pfx));
    chk({tag, ".seg"},       64'(out_seg),       64'(seg));
    chk({tag, ".rex"},       64'(out_rex),       64'(rex));
    chk({tag, ".escape"},    64'(out_escape),    64'(esc));
    chk({tag, ".opcode"},    64'(out_opcode),    64'(op));
    chk({tag, ".has_modrm"}, 64'(out_has_modrm), 64'(hm));
    chk({tag, ".modrm"},     64'(out_modrm),     64'(modrm));
    chk({tag, ".has_sib"},   64'(out_has_sib),   64'(hs));
    chk({tag, ".sib"},       64'(out_sib),       64'(sib));
    chk({tag, ".disp"},      64'(out_disp),      64'(disp));
    chk({tag, ".imm"},       out_imm,            imm);
    chk({tag, ".imm_bytes"}, 64'(out_imm_bytes), 64'(ib));
    chk({tag, ".length"},    64'(out_length),    64'(len));
    chk({tag, ".error"},     64'(out_error),     64'(err));
    chk({tag, ".in_ready"},  64'(in_ready),      64'd0);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst.in_ready",  64'(in_ready),  64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.length",    64'(out_length), 64'd0);
    chk("rst.imm",       out_imm,        64'd0);
    chk("rst.error",     64'(out_error), 64'd0);

    // 48 89 E5 : mov rbp, rsp
    send(8'h48); send(8'h89); send(8'hE5);
    wait_out("i1");
    expect_insn("i1", 6'h00, 3'd0, 4'h8, 1'b0, 8'h89, 1'b1, 8'hE5, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd3, 1'b0);
    take();

    // 66 81 C1 34 12 : add cx, 0x1234
    send(8'h66); send(8'h81); send(8'hC1); send(8'h34); send(8'h12);
    wait_out("i2");
    expect_insn("i2", 6'h01, 3'd0, 4'h0, 1'b0, 8'h81, 1'b1, 8'hC1, 1'b0, 8'h00,
                32'h0, 64'h1234, 4'd2, 4'd5, 1'b0);
    take();

    // 48 B8 imm64 : movabs rax
    send(8'h48); send(8'hB8);
    send(8'h88); send(8'h77); send(8'h66); send(8'h55);
    send(8'h44); send(8'h33); send(8'h22); send(8'h11);
    wait_out("i3");
    expect_insn("i3", 6'h00, 3'd0, 4'h8, 1'b0, 8'hB8, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h1122334455667788, 4'd8, 4'd10, 1'b0);
    take();

    // 8B 44 24 F8 : mov eax, [rsp-8], then held output
    send(8'h8B); send(8'h44); send(8'h24); send(8'hF8);
    wait_out("i4");
    expect_insn("i4", 6'h00, 3'd0, 4'h0, 1'b0, 8'h8B, 1'b1, 8'h44, 1'b1, 8'h24,
                32'hFFFFFFF8, 64'h0, 4'd0, 4'd4, 1'b0);
    in_valid = 1'b1;
    in_byte  = 8'h0F;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("hold.out_valid", 64'(out_valid),  64'd1);
      chk("hold.in_ready",  64'(in_ready),   64'd0);
      chk("hold.disp",      64'(out_disp),   64'hFFFFFFF8);
      chk("hold.length",    64'(out_length), 64'd4);
      chk("hold.sib",       64'(out_sib),    64'h24);
    end
    in_valid = 1'b0;
    take();
    @(negedge clk);
    chk("post_hs.in_ready",  64'(in_ready),  64'd1);
    chk("post_hs.out_valid", 64'(out_valid), 64'd0);

    // 0F 84 rel32 : je
    send(8'h0F); send(8'h84); send(8'h10); send(8'h00); send(8'h00); send(8'h00);
    wait_out("i5");
    expect_insn("i5", 6'h00, 3'd0, 4'h0, 1'b1, 8'h84, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h10, 4'd4, 4'd6, 1'b0);
    take();

    // 64 8B 04 25 disp32 : mov eax, fs:[abs32] via SIB base=101
    send(8'h64); send(8'h8B); send(8'h04); send(8'h25);
    send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    wait_out("i6");
    expect_insn("i6", 6'h20, 3'd4, 4'h0, 1'b0, 8'h8B, 1'b1, 8'h04, 1'b1, 8'h25,
                32'h12345678, 64'h0, 4'd0, 4'd8, 1'b0);
    take();

    // F6 C0 7F : test al, 0x7F (imm depends on ModRM.reg)
    send(8'hF6); send(8'hC0); send(8'h7F);
    wait_out("i7");
    expect_insn("i7", 6'h00, 3'd0, 4'h0, 1'b0, 8'hF6, 1'b1, 8'hC0, 1'b0, 8'h00,
                32'h0, 64'h7F, 4'd1, 4'd3, 1'b0);
    take();

    // 15 x 66 : length overflow, then 90 starts fresh
    for (int k = 0; k < 15; k++) send(8'h66);
    wait_out("ovf");
    expect_insn("ovf", 6'h01, 3'd0, 4'h0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd15, 1'b1);
    take();
    send(8'h90);
    wait_out("nop1");
    expect_insn("nop1", 6'h00, 3'd0, 4'h0, 1'b0, 8'h90, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd1, 1'b0);
    take();

    // 48 66 90 : legacy prefix after REX drops the REX
    send(8'h48); send(8'h66); send(8'h90);
    wait_out("rexclr");
    expect_insn("rexclr", 6'h01, 3'd0, 4'h0, 1'b0, 8'h90, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd3, 1'b0);
    take();

    // partial 8B 44 then reset: nothing emitted
    send(8'h8B); send(8'h44);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst.out_valid", 64'(out_valid),  64'd0);
    chk("midrst.in_ready",  64'(in_ready),   64'd1);
    chk("midrst.length",    64'(out_length), 64'd0);
    send(8'h90);
    wait_out("nop2");
    expect_insn("nop2", 6'h00, 3'd0, 4'h0, 1'b0, 8'h90, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd1, 1'b0);
    take();

    // 06 : invalid in 64-bit mode
    send(8'h06);
    wait_out("inv");
    expect_insn("inv", 6'h00, 3'd0, 4'h0, 1'b0, 8'h06, 1'b0, 8'h00, 1'b0, 8'h00,
                32'h0, 64'h0, 4'd0, 4'd1, 1'b1);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
